// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: sequential instruction prefetcher with a req/ack memory port
// and a small {pc, word} FIFO feeding the core fetch stage.
module instr_prefetch_buffer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP        = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      hold,
  input  logic                      redirect,
  input  logic [DATA_WIDTH-1:0]     redirect_pc,
  output logic                      imem_req,
  output logic [DATA_WIDTH-1:0]     imem_addr,
  input  logic                      imem_ack,
  input  logic [DATA_WIDTH-1:0]     imem_rdata,
  output logic [DATA_WIDTH-1:0]     instr,
  output logic [DATA_WIDTH-1:0]     instr_pc,
  output logic                      stall,
  output logic [$clog2(DEPTH):0]    occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d, pending_pc_q, pending_pc_d, target_pc;
  logic [DATA_WIDTH-1:0] pc_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] word_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] word_mem_d [DEPTH];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]           count_q, count_d, occ_next;
  logic                  empty, push, pop;

  assign target_pc = redirect_pc & ~DATA_WIDTH'(3);
  assign empty     = count_q == '0;
  assign stall     = empty | hold;
  assign pop       = !stall && !redirect;
  // A word acked in the same cycle as a redirect belongs to the abandoned path.
  assign push      = state_q == REQ && imem_ack && !redirect;
  assign occ_next  = count_q + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    pc_mem_d   = pc_mem_q;
    word_mem_d = word_mem_q;
    if (push) begin
      pc_mem_d[wr_ptr_q]   = fetch_pc_q;
      word_mem_d[wr_ptr_q] = imem_rdata;
    end
    rd_ptr_d = redirect ? '0 : rd_ptr_q + AW'(pop);
    wr_ptr_d = redirect ? '0 : wr_ptr_q + AW'(push);
    count_d  = redirect ? '0 : occ_next;
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect) fetch_pc_d = target_pc;
        state_d = (redirect || occ_next < FULL) ? REQ : IDLE;
      end
      REQ: begin
        if (redirect && imem_ack) fetch_pc_d = target_pc;
        else if (redirect) begin
          pending_pc_d = target_pc;
          state_d      = DRAIN;
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
          state_d    = occ_next < FULL ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (redirect) pending_pc_d = target_pc;
        if (imem_ack) begin
          fetch_pc_d = redirect ? target_pc : pending_pc_q;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = state_d != IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      pc_mem_q     <= '{default: '0};
      word_mem_q   <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      pc_mem_q     <= pc_mem_d;
      word_mem_q   <= word_mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = fetch_pc_q;
  assign instr     = empty ? NOP : word_mem_q[rd_ptr_q];
  assign instr_pc  = empty ? '0 : pc_mem_q[rd_ptr_q];
  assign occupancy = count_q;
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: directed vector table, hand sequences for reset abort and
// redirect-in-drain, then random traffic checked against a program-order stream model.
module tb_instr_prefetch_buffer;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0;

  logic        clock = 1'b0, reset = 1'b0, hold = 1'b0, redirect = 1'b0, imem_ack = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic        imem_req, stall;
  logic [31:0] imem_addr, instr, instr_pc;
  logic [2:0]  occupancy;
  int          errors = 0, checks = 0;

  instr_prefetch_buffer #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .NOP(NOP)) dut (
    .clock(clock), .reset(reset), .hold(hold), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .stall(stall), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        h, r;
    logic [31:0] rpc;
    logic        a;
    logic        req;
    logic [31:0] addr;
    logic [2:0]  occ;
    logic        st;
    logic [31:0] ipc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic vec_t mk(input logic h, r, input logic [31:0] rpc, input logic a,
                              input logic req, input logic [31:0] addr, input logic [2:0] occ,
                              input logic st, input logic [31:0] ipc);
    vec_t t;
    t.h = h; t.r = r; t.rpc = rpc; t.a = a;
    t.req = req; t.addr = addr; t.occ = occ; t.st = st; t.ipc = ipc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input string tag, input vec_t t);
    hold = t.h; redirect = t.r; redirect_pc = t.rpc; imem_ack = t.a;
    imem_rdata = mem_word(imem_addr);
    @(negedge clock);
    check({tag, " req"}, 32'(imem_req), 32'(t.req));
    check({tag, " addr"}, imem_addr, t.addr);
    check({tag, " occ"}, 32'(occupancy), 32'(t.occ));
    check({tag, " stall"}, 32'(stall), 32'(t.st));
    check({tag, " instr_pc"}, instr_pc, t.ipc);
    check({tag, " instr"}, instr, t.occ == 0 ? NOP : mem_word(t.ipc));
    @(posedge clock); #1;
  endtask

  logic [31:0] exp_pc, exp_fetch, held_addr;
  int          sz, cnt, lat, pops;
  logic        stale, live, pop_m;

  initial begin
    //            h  r  rpc           a  req addr          occ st ipc
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0,        0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h4,        1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h8,        1, 0, 32'h4));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 32'hC,        1, 1, 32'h8));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 32'h10,       2, 1, 32'h8));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 32'h14,       3, 1, 32'h8));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h18,       4, 1, 32'h8));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h18,       4, 1, 32'h8));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h18,       4, 0, 32'h8));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h18,       3, 0, 32'hC));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h1C,       3, 0, 32'h10));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h20,       3, 0, 32'h14));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h24,       3, 0, 32'h18));
    vecs.push_back(mk(0, 1, 32'h100,      0, 1, 32'h28,       3, 0, 32'h1C));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h28,       0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h28,       0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h100,      0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h100,      0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h104,      1, 0, 32'h100));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFD, 1, 1, 32'h108,     1, 0, 32'h104));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0,        1, 0, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h4,        1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 32'h8,        1, 1, 32'h4));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 32'hC,        2, 1, 32'h4));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 32'h10,       3, 1, 32'h4));
    vecs.push_back(mk(1, 1, 32'h200,      0, 0, 32'h14,       4, 1, 32'h4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h200,      0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h200,      0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h204,      1, 0, 32'h200));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h204,      0, 1, 32'h0));

    @(negedge clock);
    check("reset req", 32'(imem_req), 32'h0);
    check("reset addr", imem_addr, 32'h0);
    check("reset occ", 32'(occupancy), 32'h0);
    check("reset stall", 32'(stall), 32'h1);
    check("reset instr", instr, NOP);
    check("reset instr_pc", instr_pc, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Reset mid-transaction aborts the request; a stale ack afterwards is ignored.
    reset = 1'b0; imem_ack = 1'b0; hold = 1'b0; redirect = 1'b0;
    #1;
    check("abort req", 32'(imem_req), 32'h0);
    check("abort addr", imem_addr, 32'h0);
    check("abort occ", 32'(occupancy), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    apply("stale_ack", mk(0, 0, 32'h0,  1, 0, 32'h0,  0, 1, 32'h0));
    apply("drain_in",  mk(0, 1, 32'h40, 0, 1, 32'h0,  0, 1, 32'h0));
    apply("drain_ovr", mk(0, 1, 32'h80, 0, 1, 32'h0,  0, 1, 32'h0));
    apply("drain_ack", mk(0, 0, 32'h0,  1, 1, 32'h0,  0, 1, 32'h0));
    apply("newest",    mk(0, 0, 32'h0,  1, 1, 32'h80, 0, 1, 32'h0));
    apply("newest_q",  mk(0, 0, 32'h0,  0, 1, 32'h84, 1, 0, 32'h80));
    apply("newest_e",  mk(0, 0, 32'h0,  0, 1, 32'h84, 0, 1, 32'h0));

    // Random traffic against a program-order model: pops must walk the PC stream
    // from the latest redirect target, and only non-abandoned acks enter the queue.
    reset = 1'b0; imem_ack = 1'b0; hold = 1'b0; redirect = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    exp_pc = 32'h0; exp_fetch = 32'h0; sz = 0; cnt = 0; lat = 0; pops = 0; stale = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      hold = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 24) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      if (imem_req) begin
        if (cnt == 0) begin
          lat = $urandom_range(0, 3);
          held_addr = imem_addr;
        end else check("addr stable", imem_addr, held_addr);
        imem_ack = (cnt == lat);
        cnt = imem_ack ? 0 : cnt + 1;
      end else begin
        check("req held until ack", 32'(cnt), 32'h0);
        imem_ack = ($urandom_range(0, 7) == 0);
      end
      imem_rdata = imem_req ? mem_word(imem_addr) : $urandom;
      @(negedge clock);
      live  = imem_req && imem_ack && !redirect && !stale;
      pop_m = sz != 0 && !hold && !redirect;
      check("rnd stall", 32'(stall), 32'((sz == 0) || hold));
      check("rnd occ", 32'(occupancy), 32'(sz));
      if (sz == 0) check("rnd nop", instr, NOP);
      if (pop_m) begin
        check("rnd pop pc", instr_pc, exp_pc);
        check("rnd pop instr", instr, mem_word(exp_pc));
        exp_pc += 32'h4;
        pops++;
      end
      if (live) begin
        check("rnd fetch addr", imem_addr, exp_fetch);
        exp_fetch += 32'h4;
      end
      if (imem_req) stale = imem_ack ? 1'b0 : (stale || redirect);
      if (redirect) begin
        sz = 0;
        exp_pc = redirect_pc & ~32'h3;
        exp_fetch = redirect_pc & ~32'h3;
      end else sz = sz + int'(live) - int'(pop_m);
      check("rnd credit", 32'(sz <= DEPTH), 32'h1);
      @(posedge clock); #1;
    end
    check("rnd progress", 32'(pops >= 200), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_buffer.md
# instr_prefetch_buffer

Sequential instruction prefetcher that feeds the core's `data_in`/`stall` inputs from an external instruction memory with a req/ack handshake. It issues word-address fetches ahead of the core and queues the returned words in a small FIFO. It presents the oldest word to the fetch stage and asserts `stall` whenever no instruction is ready. A redirect input flushes the queue and restarts fetching at a new PC. Any in-flight response is discarded safely.

## Interface
- `DATA_WIDTH`, 32: instruction and address width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP`, 32'h0000_0000: value driven on `instr` when the FIFO is empty.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `hold`  in  1  external stall request; blocks the pop and forces `stall`=1.
- `redirect`  in  1  flush and restart at `redirect_pc`; one-cycle pulse.
- `redirect_pc`  in  DATA_WIDTH  new fetch address; word-aligned, bits[1:0] ignored.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  DATA_WIDTH  fetch address; stable while `imem_req`=1.
- `imem_ack`  in  1  response valid; `imem_rdata` is sampled in this cycle.
- `imem_rdata`  in  DATA_WIDTH  returned instruction word.
- `instr`  out  DATA_WIDTH  head-of-queue instruction, drives core `data_in`.
- `instr_pc`  out  DATA_WIDTH  address of `instr`.
- `stall`  out  1  drives core `stall`; equals (empty OR `hold`), combinational.
- `occupancy`  out  log2(DEPTH)+1  valid entries in the FIFO.

## Operation
- The FIFO stores {pc, word} pairs. A pop occurs every cycle in which `stall`=0 and `redirect`=0.
- Credit rule: a new request may start only when occupancy + outstanding < DEPTH, counting the pop in the same cycle. At most one request is outstanding, so overflow is impossible.
- FSM states:
  - IDLE: `imem_req`=0. Goes to REQ when the credit rule allows.
  - REQ: `imem_req`=1 and `imem_addr`=fetch_pc.
    - On `imem_ack`: push {fetch_pc, rdata}; fetch_pc += 4. Stay in REQ if credit remains, otherwise go to IDLE. Back-to-back requests are allowed.
  - DRAIN: `imem_req`=1 and the address is held. Entered when `redirect` arrives in REQ without `imem_ack`. `redirect_pc` is latched into pending_pc. On `imem_ack`, the data is dropped, fetch_pc is set to pending_pc, and the FSM goes to REQ.
- Redirect:
  - The FIFO is cleared on the same edge.
  - In IDLE: fetch_pc := redirect_pc, then go to REQ.
  - In REQ with `imem_ack` in the same cycle: the acked word is discarded, fetch_pc := redirect_pc, and the FSM stays in REQ.
  - In DRAIN: pending_pc is overwritten; the newest redirect wins.
- `imem_req` is never dropped mid-handshake. Once asserted, it stays high until `imem_ack`.
- `imem_ack` while `imem_req`=0 is a protocol error and is ignored.
- fetch_pc wraps modulo 2^DATA_WIDTH.
- Read and write pointers wrap modulo DEPTH. Push and pop may happen in the same cycle at any occupancy, including full (push allowed via credit) and empty (no pop).

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr`=`NOP`, `instr_pc`=0, `stall`=1, `occupancy`=0. FSM state is IDLE.
- Asserting `reset` mid-transaction aborts the transaction immediately. A later stale `imem_ack` is ignored because `imem_req`=0.
- `imem_req` rises on the first edge after `reset` deasserts (cycle 1).
- Ack in cycle k: the word is visible on `instr` and `stall`=0 in cycle k+1, if `hold`=0.
- Redirect in cycle n with no request outstanding:
  - `occupancy`=0 and `stall`=1 in cycle n+1.
  - `imem_req` with `imem_addr`=redirect_pc in cycle n+1.
- Redirect in cycle n with a request outstanding: the new address is issued the cycle after the discarded ack.
- Sustained throughput is 1 instruction/cycle when memory acks every cycle.

## Test plan
- Reset release, memory acks every cycle with rdata = addr ^ 32'hA5A5_0000:
  - `instr_pc` = 0, 4, 8, … with matching `instr`, starting cycle 2.
  - `stall`=0 from cycle 2 onward.
- `hold`=1 for 10 cycles: `occupancy` saturates at 4, `imem_req` drops, and no ack is lost. On release, 4 pops occur then streaming resumes, with the PC sequence unbroken.
- Memory with 3-cycle ack latency: `imem_addr` stays stable during each wait. `stall` toggles so that each instruction is consumed exactly once and in order.
- Redirect to 32'h0000_0100 while a request to 0x10 is pending:
  - The 0x10 data is discarded and never appears on `instr`.
  - The next `imem_addr` is 0x100, and `instr_pc` resumes at 0x100.
- Redirect in the same cycle as an ack plus a pop: that word is dropped, `occupancy`=0 on the next cycle, and fetching continues from redirect_pc.
- Redirect fetch_pc to 32'hFFFF_FFFC: the next addresses are 0xFFFF_FFFC then 0x0000_0000 (wrap).
